avalon_pio_in_capture: RTL and testbench



---
 rtl/pio_pkg.sv | 23 ++
 rtl/avalon_pio_in_capture_if.sv | 23 ++
 rtl/pio_sync_chain.sv | 32 +++
 rtl/avalon_pio_in_capture.sv | 128 ++++++++++++
 tb/tb_avalon_pio_in_capture.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM PIO input-capture port: bus widths,
// register word addresses and the encodings of the EDGE_TYPE / IRQ_MODE
// parameters.
package pio_pkg;

   localparam int AV_ADDR_W = 2;
   localparam int AV_DATA_W = 32;

   typedef enum logic [AV_ADDR_W-1:0] {
      ADDR_DATA = 2'd0,
      ADDR_RSVD = 2'd1,
      ADDR_MASK = 2'd2,
      ADDR_EDGE = 2'd3
   } pio_addr_e;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   localparam int IRQ_LEVEL = 0;
   localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/avalon_pio_in_capture_if.sv
// Avalon-MM slave bus bundle for the PIO input-capture port.
// The host side drives the request, the PIO returns registered read data.
interface avalon_pio_in_capture_if;
   import pio_pkg::*;

   logic [AV_ADDR_W-1:0] address;
   logic                 chipselect;
   logic                 read;
   logic                 write_n;
   logic [AV_DATA_W-1:0] writedata;
   logic [AV_DATA_W-1:0] readdata;

   modport master (
      output address, chipselect, read, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, read, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/pio_sync_chain.sv
// Per-bit flip-flop synchroniser for the asynchronous PIO inputs.
// STAGES = 0 passes the input straight through (inputs already in clk domain).
module pio_sync_chain #(
   parameter int               WIDTH       = 32,
   parameter int               STAGES      = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   if (STAGES == 0) begin : g_bypass
      assign o_q = i_d;
   end else begin : g_sync
      logic [WIDTH-1:0] r_stage [STAGES];

      // shift the raw inputs through STAGES flops; all stages reset to RESET_VALUE
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k < STAGES; k++) r_stage[k] <= RESET_VALUE;
         end else begin
            r_stage[0] <= i_d;
            for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
         end
      end

      assign o_q = r_stage[STAGES-1];
   end

endmodule

// File: rtl/avalon_pio_in_capture.sv
// Read-only Avalon-MM PIO input port with synchronised inputs, programmable
// edge detection, sticky write-1-to-clear edge capture, per-bit IRQ mask and
// a registered interrupt output.
//   word 0 DATA (RO, synchronised inputs)   word 1 reserved (reads 0)
//   word 2 IRQMASK (RW)                     word 3 EDGECAP (R, W1C per bit)
module avalon_pio_in_capture
   import pio_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter int          SYNC_STAGES = 2,
   parameter int          EDGE_TYPE   = EDGE_RISE,
   parameter int          IRQ_MODE    = IRQ_EDGE,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   avalon_pio_in_capture_if.slave s_avl,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic                  irq
);

   if (DATA_WIDTH < 1 || DATA_WIDTH > AV_DATA_W) begin : g_bad_width
      $error("avalon_pio_in_capture: DATA_WIDTH must be 1..32");
   end
   if (SYNC_STAGES == 1 || SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("avalon_pio_in_capture: SYNC_STAGES must be 0 or 2..4");
   end
   if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
      $error("avalon_pio_in_capture: EDGE_TYPE must be 0, 1 or 2");
   end
   if (IRQ_MODE != IRQ_LEVEL && IRQ_MODE != IRQ_EDGE) begin : g_bad_irq
      $error("avalon_pio_in_capture: IRQ_MODE must be 0 or 1");
   end

   localparam logic [DATA_WIDTH-1:0] RST_V = RESET_VALUE[DATA_WIDTH-1:0];

   logic [DATA_WIDTH-1:0] w_in_s;
   logic [DATA_WIDTH-1:0] w_rise;
   logic [DATA_WIDTH-1:0] w_fall;
   logic [DATA_WIDTH-1:0] w_edge;
   logic [DATA_WIDTH-1:0] w_clr;
   logic [DATA_WIDTH-1:0] w_src;
   logic [AV_DATA_W-1:0]  w_rd_mux;
   logic                  w_wr;
   logic                  w_wr_mask;
   logic                  w_wr_edge;

   logic [DATA_WIDTH-1:0] r_prev;
   logic [DATA_WIDTH-1:0] r_edgecap;
   logic [DATA_WIDTH-1:0] r_irqmask;
   logic [AV_DATA_W-1:0]  r_readdata;
   logic                  r_irq;

   pio_sync_chain #(
      .WIDTH       (DATA_WIDTH),
      .STAGES      (SYNC_STAGES),
      .RESET_VALUE (RST_V)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (in_port),
      .o_q   (w_in_s)
   );

   assign w_wr      = s_avl.chipselect & ~s_avl.write_n;
   assign w_wr_mask = w_wr & (s_avl.address == ADDR_MASK);
   assign w_wr_edge = w_wr & (s_avl.address == ADDR_EDGE);
   assign w_clr     = w_wr_edge ? s_avl.writedata[DATA_WIDTH-1:0] : '0;

   assign w_rise = w_in_s & ~r_prev;
   assign w_fall = ~w_in_s & r_prev;

   // select which transitions count as an edge
   always_comb begin
      case (EDGE_TYPE)
         EDGE_FALL: w_edge = w_fall;
         EDGE_ANY:  w_edge = w_rise | w_fall;
         default:   w_edge = w_rise;
      endcase
   end

   assign w_src = (IRQ_MODE == IRQ_LEVEL) ? w_in_s : r_edgecap;

   // previous synchronised sample; after reset the first compare is against RESET_VALUE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_prev <= RST_V;
      else       r_prev <= w_in_s;
   end

   // sticky capture; a new edge wins over a same-cycle clear of that bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_edgecap <= '0;
      else       r_edgecap <= w_edge | (r_edgecap & ~w_clr);
   end

   // interrupt mask register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_irqmask <= '0;
      else if (w_wr_mask) r_irqmask <= s_avl.writedata[DATA_WIDTH-1:0];
   end

   // zero-extended read mux; reads never modify state
   always_comb begin
      w_rd_mux = '0;
      case (pio_addr_e'(s_avl.address))
         ADDR_DATA: w_rd_mux[DATA_WIDTH-1:0] = w_in_s;
         ADDR_MASK: w_rd_mux[DATA_WIDTH-1:0] = r_irqmask;
         ADDR_EDGE: w_rd_mux[DATA_WIDTH-1:0] = r_edgecap;
         default:   w_rd_mux = '0;
      endcase
   end

   // read data registered every cycle, so a same-cycle write is not yet visible
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_readdata <= '0;
      else       r_readdata <= w_rd_mux;
   end

   // registered interrupt, one clock behind its source
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_irq <= 1'b0;
      else       r_irq <= |(w_src & r_irqmask);
   end

   assign s_avl.readdata = r_readdata;
   assign irq            = r_irq;

endmodule

// File: tb/tb_avalon_pio_in_capture.sv
// Scoreboard bench: each stimulus step pushes the expected read data / irq
// level into a queue; the monitor pops and compares after the clock edge at
// which the DUT produces them.
module tb_avalon_pio_in_capture;
   import pio_pkg::*;

   typedef struct {
      string       nm;
      logic [31:0] v;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_a;
   logic [7:0]  in_b;
   logic        irq_a;
   logic        irq_b;

   logic irq_req_a = 1'b0;
   logic irq_req_b = 1'b0;
   logic rd_vld_a  = 1'b0;
   logic rd_vld_b  = 1'b0;
   logic irq_vld_a = 1'b0;
   logic irq_vld_b = 1'b0;

   exp_t rd_qa[$];
   exp_t rd_qb[$];
   exp_t irq_qa[$];
   exp_t irq_qb[$];

   int n_checks = 0;
   int n_pass   = 0;

   avalon_pio_in_capture_if bus_a ();
   avalon_pio_in_capture_if bus_b ();

   avalon_pio_in_capture #(
      .DATA_WIDTH (32), .SYNC_STAGES (2), .EDGE_TYPE (0), .IRQ_MODE (1), .RESET_VALUE (32'h0)
   ) dut_a (
      .clk (clk), .reset (reset), .s_avl (bus_a), .in_port (in_a), .irq (irq_a)
   );

   avalon_pio_in_capture #(
      .DATA_WIDTH (8), .SYNC_STAGES (2), .EDGE_TYPE (2), .IRQ_MODE (0), .RESET_VALUE (32'h0)
   ) dut_b (
      .clk (clk), .reset (reset), .s_avl (bus_b), .in_port (in_b), .irq (irq_b)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   // monitor: note which outputs become due at this edge
   always @(posedge clk) begin
      rd_vld_a  <= bus_a.chipselect & bus_a.read;
      rd_vld_b  <= bus_b.chipselect & bus_b.read;
      irq_vld_a <= irq_req_a;
      irq_vld_b <= irq_req_b;
   end

   // monitor: compare due outputs against the scoreboard
   always @(negedge clk) begin : mon
      exp_t e;
      if (rd_vld_a && rd_qa.size() > 0) begin
         e = rd_qa.pop_front();
         check(e.nm, bus_a.readdata, e.v);
      end
      if (irq_vld_a && irq_qa.size() > 0) begin
         e = irq_qa.pop_front();
         check(e.nm, {31'b0, irq_a}, e.v);
      end
      if (rd_vld_b && rd_qb.size() > 0) begin
         e = rd_qb.pop_front();
         check(e.nm, bus_b.readdata, e.v);
      end
      if (irq_vld_b && irq_qb.size() > 0) begin
         e = irq_qb.pop_front();
         check(e.nm, {31'b0, irq_b}, e.v);
      end
   end

   task automatic idle_bus();
      bus_a.chipselect = 1'b0; bus_a.read = 1'b0; bus_a.write_n = 1'b1;
      bus_a.address = 2'd0;    bus_a.writedata = 32'h0;
      bus_b.chipselect = 1'b0; bus_b.read = 1'b0; bus_b.write_n = 1'b1;
      bus_b.address = 2'd0;    bus_b.writedata = 32'h0;
      irq_req_a = 1'b0;        irq_req_b = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one bus cycle: optional write, optional read (expect rexp after the
   // coming edge), optional irq check (expect iexp after the coming edge)
   task automatic step(input bit sel, input bit wr, input bit rd, input logic [1:0] a,
                       input logic [31:0] wd, input logic [31:0] rexp,
                       input bit ichk, input logic iexp, input string nm);
      exp_t e;
      if (!sel) begin
         bus_a.chipselect = wr | rd; bus_a.write_n = ~wr; bus_a.read = rd;
         bus_a.address = a;          bus_a.writedata = wd; irq_req_a = ichk;
      end else begin
         bus_b.chipselect = wr | rd; bus_b.write_n = ~wr; bus_b.read = rd;
         bus_b.address = a;          bus_b.writedata = wd; irq_req_b = ichk;
      end
      if (rd) begin
         e.nm = {nm, ".rd"}; e.v = rexp;
         if (!sel) rd_qa.push_back(e); else rd_qb.push_back(e);
      end
      if (ichk) begin
         e.nm = {nm, ".irq"}; e.v = {31'b0, iexp};
         if (!sel) irq_qa.push_back(e); else irq_qb.push_back(e);
      end
      @(negedge clk);
      idle_bus();
   endtask

   initial begin
      reset = 1'b1;
      in_a  = 32'h0;
      in_b  = 8'h0;
      idle_bus();
      tick(2);
      step(0, 0, 1, ADDR_DATA, 0, 32'h0, 1, 1'b0, "rst_state");
      reset = 1'b0;
      tick(2);

      // DATA path: visible two clocks after the pin change
      in_a = 32'hA5A5_0F0F;
      tick(1);
      step(0, 0, 1, ADDR_DATA, 0, 32'h0,         0, 1'b0, "data_early");
      step(0, 0, 1, ADDR_DATA, 0, 32'hA5A5_0F0F, 0, 1'b0, "data_rd");
      step(0, 0, 1, ADDR_EDGE, 0, 32'hA5A5_0F0F, 1, 1'b0, "edge_data");
      step(0, 0, 1, ADDR_EDGE, 0, 32'hA5A5_0F0F, 0, 1'b0, "edge_sticky");
      step(0, 1, 1, ADDR_EDGE, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 0, 1'b0, "w1c_prewr");
      step(0, 0, 1, ADDR_EDGE, 0, 32'h0, 0, 1'b0, "w1c_all");
      step(0, 1, 1, ADDR_RSVD, 32'hFFFF_FFFF, 32'h0, 0, 1'b0, "rsvd_wr");
      step(0, 1, 1, ADDR_DATA, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 0, 1'b0, "data_wr_ign");
      step(0, 0, 1, ADDR_RSVD, 0, 32'h0, 0, 1'b0, "rsvd_rd");
      step(0, 0, 1, ADDR_MASK, 0, 32'h0, 0, 1'b0, "mask_untouched");

      // falling edges are ignored in rising mode
      in_a = 32'h0;
      tick(4);
      step(0, 0, 1, ADDR_EDGE, 0, 32'h0, 1, 1'b0, "fall_ignored");

      // rising edge on bit 0 with mask bit 0 set
      step(0, 1, 1, ADDR_MASK, 32'h1, 32'h0, 0, 1'b0, "mask_prewr");
      step(0, 0, 1, ADDR_MASK, 0, 32'h1, 1, 1'b0, "mask_rd");
      in_a = 32'h1;
      tick(2);
      step(0, 0, 1, ADDR_EDGE, 0, 32'h0, 1, 1'b0, "rise_early");
      step(0, 0, 1, ADDR_EDGE, 0, 32'h1, 1, 1'b1, "rise_cap");
      in_a = 32'h0;
      tick(4);
      step(0, 0, 1, ADDR_EDGE, 0, 32'h1, 1, 1'b1, "fall_nocap");

      // clear and new edge on the same bit in the same cycle: edge wins
      in_a = 32'h1;
      tick(2);
      step(0, 1, 1, ADDR_EDGE, 32'h1, 32'h1, 1, 1'b1, "race_wr");
      step(0, 0, 1, ADDR_EDGE, 0, 32'h1, 1, 1'b1, "w1c_race");
      step(0, 1, 1, ADDR_EDGE, 32'h1, 32'h1, 0, 1'b0, "w1c_pre");
      step(0, 0, 1, ADDR_EDGE, 0, 32'h0, 1, 1'b0, "w1c_clear");

      // masking of a captured bit 4
      step(0, 1, 0, ADDR_MASK, 32'h0, 32'h0, 0, 1'b0, "mask_zero");
      in_a = 32'h11;
      tick(4);
      step(0, 0, 1, ADDR_EDGE, 0, 32'h10, 1, 1'b0, "mask_off");
      step(0, 1, 1, ADDR_MASK, 32'h10, 32'h0, 1, 1'b0, "mask_wr");
      step(0, 0, 1, ADDR_MASK, 0, 32'h10, 1, 1'b1, "mask_on");
      step(0, 1, 1, ADDR_EDGE, 32'h10, 32'h10, 1, 1'b1, "clr_wr");
      step(0, 0, 1, ADDR_EDGE, 0, 32'h0, 1, 1'b0, "clr_irq");

      // reset in the middle of traffic with irq active
      in_a = 32'h1;
      tick(4);
      in_a = 32'h11;
      tick(4);
      step(0, 0, 1, ADDR_EDGE, 0, 32'h10, 1, 1'b1, "pre_rst");
      reset = 1'b1;
      step(0, 1, 1, ADDR_MASK, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, "rst_mid");
      step(0, 0, 1, ADDR_EDGE, 0, 32'h0, 1, 1'b0, "rst_hold");
      reset = 1'b0;
      step(0, 0, 1, ADDR_MASK, 0, 32'h0, 1, 1'b0, "post_rst_mask");
      step(0, 0, 1, ADDR_EDGE, 0, 32'h0, 1, 1'b0, "post_rst_edge0");
      tick(1);
      step(0, 0, 1, ADDR_EDGE, 0, 32'h11, 1, 1'b0, "post_rst_cmp");

      // 8-bit instance: any-edge capture, level irq
      in_b = 8'h81;
      step(1, 1, 0, ADDR_MASK, 32'hFFFF_FF80, 32'h0, 0, 1'b0, "b_mask_wr");
      step(1, 0, 1, ADDR_DATA, 0, 32'h0, 1, 1'b0, "b_data_early");
      step(1, 0, 1, ADDR_DATA, 0, 32'h81, 1, 1'b1, "b_data_irq");
      step(1, 0, 1, ADDR_MASK, 0, 32'h80, 0, 1'b0, "b_mask_trunc");
      step(1, 0, 1, ADDR_EDGE, 0, 32'h81, 0, 1'b0, "b_edge_rise");
      step(1, 1, 0, ADDR_EDGE, 32'hFF, 32'h0, 0, 1'b0, "b_clr");
      in_b = 8'h00;
      tick(4);
      step(1, 0, 1, ADDR_EDGE, 0, 32'h81, 1, 1'b0, "b_fall_any");
      in_b = 8'h80;
      tick(3);
      step(1, 0, 1, ADDR_DATA, 0, 32'h80, 1, 1'b1, "b_level_again");

      tick(3);
      if (rd_qa.size() + irq_qa.size() + rd_qb.size() + irq_qb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0",
                  rd_qa.size() + irq_qa.size() + rd_qb.size() + irq_qb.size());
         n_checks += rd_qa.size() + irq_qa.size() + rd_qb.size() + irq_qb.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
